debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent debounced channels, range 1..32.
REQ-002 Parameter STABLE_CNT, default 3: consecutive agreeing samples needed to change output, range 1..255.
REQ-003 Parameter PRESCALE, default 1: clock cycles per sample tick, range 1..65535.
REQ-004 Parameter SYNC_STAGES, default 2: input synchroniser flops per channel, range 1..4.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset of all state.
REQ-007 sin  input  N_CH  raw, asynchronous switch/button levels, one bit per channel.
REQ-008 sout  output  N_CH  debounced level per channel, registered.
REQ-009 rise  output  N_CH  one-cycle pulse per channel when sout goes 0->1, registered.
REQ-010 fall  output  N_CH  one-cycle pulse per channel when sout goes 1->0, registered.
REQ-011 tick  output  1  one-cycle pulse marking each sample instant, registered.

Function
REQ-012 Each sin bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the channel sample s[i].
REQ-013 A prescaler counter, width clog2(PRESCALE) (min 1), SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be high in the cycle the counter equals PRESCALE-1.
REQ-014 PRESCALE=1 SHALL make tick high every cycle.
REQ-015 Each channel SHALL hold a stability counter cnt[i] of width clog2(STABLE_CNT+1); channels SHALL be fully independent.
REQ-016 State update per channel occurs only in cycles where tick is high; with tick low, cnt, sout unchanged.
REQ-017 On tick, s[i]==sout[i]: cnt[i] SHALL clear to 0 (any agreeing sample aborts a pending change).
REQ-018 On tick, s[i]!=sout[i] and cnt[i]<STABLE_CNT-1: cnt[i] SHALL increment by 1.
REQ-019 On tick, s[i]!=sout[i] and cnt[i]==STABLE_CNT-1: sout[i] SHALL take s[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-020 rise[i]/fall[i] SHALL assert on the same edge sout[i] changes, for exactly one cycle, and never both at once.
REQ-021 cnt[i] SHALL never exceed STABLE_CNT-1; no wrap-around of cnt.
REQ-022 With PRESCALE=1, a clean step on sin[i] held steady SHALL change sout[i] exactly SYNC_STAGES+STABLE_CNT rising edges after sin changes before the first edge.
REQ-023 General latency SHALL be SYNC_STAGES cycles plus STABLE_CNT ticks, plus up to PRESCALE-1 cycles of tick phase.
REQ-024 STABLE_CNT=1 SHALL make sout follow s on every tick (synchronised, sampled, no filtering).
REQ-025 Pulses shorter than STABLE_CNT consecutive ticks (as seen at s) SHALL never change sout.
REQ-026 Simultaneous changes on several channels SHALL be processed in the same cycles with no interaction.

Reset
REQ-027 reset high SHALL immediately clear synchroniser flops, prescaler, all cnt, sout, rise, fall, tick to 0, regardless of clk.
REQ-028 reset asserted mid-count SHALL discard the pending change; counting restarts from 0 after release.
REQ-029 After release, prescaler SHALL start at 0, so first tick occurs on the PRESCALE-th rising edge.
REQ-030 sin held high through reset release SHALL produce a normal rise pulse after the REQ-022/023 latency (sout reset value is 0).

Verification
REQ-031 N_CH=4, STABLE_CNT=3, PRESCALE=1, SYNC_STAGES=2: sin=0001 step, held -> sout[0]=1 and rise=0001 for one cycle, exactly 5 edges later; other channels stay 0.
REQ-032 Same config: sin[1] bounce 1,1,0,1,1,1 per cycle -> sout[1] rises only 5 edges after last 0->1 transition; no early rise, no fall.
REQ-033 PRESCALE=4, STABLE_CNT=2: tick every 4th cycle; sin[2] step -> sout[2] changes on the 2nd tick after s[2] changes; fall tested symmetrically with 1->0 step.
REQ-034 sin=1111 held; assert reset for 1 cycle mid-count (between edges, asynchronous) -> all outputs 0 immediately, rise=1111 issued once 5 edges after release.
REQ-035 STABLE_CNT=1, PRESCALE=1: random sin -> sout equals sin delayed SYNC_STAGES+1 cycles; rise/fall match edges of sout, never both high.
REQ-036 Random glitch stress on all channels, reference model compare: sout, rise, fall cycle-exact; assert cnt<=STABLE_CNT-1 always.

Source files
------------

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel synchroniser plus tick-sampled counter debouncer
// A sout bit changes only after STABLE_CNT consecutive disagreeing tick samples.
module debounce_bank #(
    parameter int N_CH        = 4,
    parameter int STABLE_CNT  = 3,
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sin,
    output logic [N_CH-1:0] sout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [N_CH-1:0]         sync_q [SYNC_STAGES];
    logic [N_CH-1:0]         sync_d [SYNC_STAGES];
    logic [PW-1:0]           presc_q, presc_d;
    logic                    tick_q, tick_d;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]         sout_q, sout_d;
    logic [N_CH-1:0]         rise_q, rise_d;
    logic [N_CH-1:0]         fall_q, fall_d;
    logic [N_CH-1:0]         s;

    always_comb begin
        sync_d[0] = sin;
        for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // tick_q is registered from the next counter value so it is high exactly
    // while the counter holds PRESCALE-1.
    always_comb begin
        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PRE_LAST);
    end

    always_comb begin
        cnt_d  = cnt_q;
        sout_d = sout_q;
        rise_d = '0;
        fall_d = '0;
        if (tick_q) begin
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] == sout_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= CNT_LAST) begin
                    cnt_d[i]  = '0;
                    sout_d[i] = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            presc_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            sout_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_d[j];
            end
            presc_q <= presc_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sout = sout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - three debounce_bank configurations against a sample-window model
module tb_debounce_bank;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sin_a = '0, sin_b = '0, sin_c = '0;
    logic [3:0] sout_a, rise_a, fall_a;
    logic [3:0] sout_b, rise_b, fall_b;
    logic [3:0] sout_c, rise_c, fall_c;
    logic       tick_a, tick_b, tick_c;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(4), .STABLE_CNT(3), .PRESCALE(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .sin(sin_a), .sout(sout_a),
        .rise(rise_a), .fall(fall_a), .tick(tick_a));
    debounce_bank #(.N_CH(4), .STABLE_CNT(2), .PRESCALE(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .sin(sin_b), .sout(sout_b),
        .rise(rise_b), .fall(fall_b), .tick(tick_b));
    debounce_bank #(.N_CH(4), .STABLE_CNT(1), .PRESCALE(1), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset(reset), .sin(sin_c), .sout(sout_c),
        .rise(rise_c), .fall(fall_c), .tick(tick_c));

    int n_cmp = 0;
    int n_err = 0;

    // Model: sout flips once the last STABLE_CNT tick samples all differ from it.
    int         mp [3] = '{1, 4, 1};
    int         mk [3] = '{3, 2, 1};
    int         n_edge [3];
    int         n_samp [3];
    logic [3:0] hist [3][64];
    logic [3:0] samp [3][64];
    logic [3:0] m_sout [3], m_rise [3], m_fall [3], pend [3];
    logic       m_tick [3];
    logic       rst_prev = 1'b1;

    task automatic chk(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: actual %0h required %0h at %0t", tag, idx, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        n_edge[k] = 0;
        n_samp[k] = 0;
        m_sout[k] = '0;
        m_rise[k] = '0;
        m_fall[k] = '0;
        m_tick[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        int         n;
        logic [3:0] smp;
        bit         all_diff;
        n = n_edge[k] + 1;
        m_rise[k] = '0;
        m_fall[k] = '0;
        if (n - 1 >= 1 && (n - 1) % mp[k] == mp[k] - 1) begin
            smp = (n - 1 >= S) ? hist[k][(n - 1 - S) % 64] : 4'h0;
            samp[k][n_samp[k] % 64] = smp;
            n_samp[k]++;
            for (int ch = 0; ch < 4; ch++) begin
                if (n_samp[k] >= mk[k]) begin
                    all_diff = 1'b1;
                    for (int j = 1; j <= mk[k]; j++) begin
                        if (samp[k][(n_samp[k] - j) % 64][ch] == m_sout[k][ch]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_sout[k][ch] = smp[ch];
                        if (smp[ch]) m_rise[k][ch] = 1'b1;
                        else         m_fall[k][ch] = 1'b1;
                    end
                end
            end
        end
        hist[k][(n - 1) % 64] = pend[k];
        n_edge[k] = n;
        m_tick[k] = (n % mp[k] == mp[k] - 1);
    endtask

    logic [3:0] d_sout [3], d_rise [3], d_fall [3], d_sin [3];
    logic       d_tick [3];

    always @(negedge clk) begin
        d_sout = '{sout_a, sout_b, sout_c};
        d_rise = '{rise_a, rise_b, rise_c};
        d_fall = '{fall_a, fall_b, fall_c};
        d_tick = '{tick_a, tick_b, tick_c};
        d_sin  = '{sin_a, sin_b, sin_c};
        for (int k = 0; k < 3; k++) begin
            if (!rst_prev) model_step(k);
            if (reset) model_reset(k);
            chk("sout", k, d_sout[k], m_sout[k]);
            chk("rise", k, d_rise[k], m_rise[k]);
            chk("fall", k, d_fall[k], m_fall[k]);
            chk("tick", k, d_tick[k], m_tick[k]);
            chk("rise_and_fall", k, d_rise[k] & d_fall[k], 0);
            pend[k] = d_sin[k];
        end
        for (int ch = 0; ch < 4; ch++) begin
            chk("a_cnt_over", ch, (dut_a.cnt_q[ch] > 2) ? 1 : 0, 0);
            chk("b_cnt_over", ch, (dut_b.cnt_q[ch] > 1) ? 1 : 0, 0);
            chk("c_cnt_over", ch, (dut_c.cnt_q[ch] > 0) ? 1 : 0, 0);
        end
        rst_prev = reset;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [5:0] seq;
        int         nt;
        bit         found;
        seq = 6'b111011;

        repeat (3) cyc();
        chk("rst_sout", 0, sout_a, 0);
        chk("rst_tick", 0, tick_a, 0);
        reset = 1'b0;
        repeat (4) cyc();

        sin_a = 4'b0001;
        repeat (4) cyc();
        chk("step_early", 0, sout_a, 0);
        cyc();
        chk("step_sout", 0, sout_a, 4'b0001);
        chk("step_rise", 0, rise_a, 4'b0001);
        cyc();
        chk("step_rise_once", 0, rise_a, 0);
        repeat (3) cyc();

        for (int i = 0; i < 6; i++) begin
            sin_a[1] = seq[i];
            cyc();
        end
        chk("bounce_hold", 0, sout_a, 4'b0001);
        cyc();
        chk("bounce_early", 0, rise_a, 0);
        cyc();
        chk("bounce_rise", 0, rise_a, 4'b0010);
        chk("bounce_sout", 0, sout_a, 4'b0011);
        sin_a = 4'b0000;
        repeat (8) cyc();
        chk("fall_settled", 0, sout_a, 0);

        nt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (tick_b) nt++;
        end
        chk("presc_tick_count", 1, nt, 4);
        sin_b = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cyc();
            if (rise_b != 0) found = 1'b1;
        end
        chk("presc_rise_seen", 1, found, 1);
        chk("presc_rise", 1, rise_b, 4'b0100);
        sin_b = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cyc();
            if (fall_b != 0) found = 1'b1;
        end
        chk("presc_fall_seen", 1, found, 1);
        chk("presc_fall", 1, fall_b, 4'b0100);

        for (int i = 0; i < 300; i++) begin
            sin_c = 4'($urandom);
            if ($urandom_range(0, 3) == 0 || (i % 50) < 20) sin_a = sin_a ^ 4'($urandom);
            if ($urandom_range(0, 5) == 0) sin_b = sin_b ^ 4'($urandom);
            cyc();
        end
        sin_a = '0;
        sin_b = '0;
        sin_c = '0;
        repeat (20) cyc();

        sin_a = 4'b0011;
        repeat (10) cyc();
        chk("rst_pre", 0, sout_a, 4'b0011);
        sin_a = 4'b1111;
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        chk("rst_async_sout", 0, sout_a, 0);
        chk("rst_async_tick", 0, tick_a, 0);
        cyc();
        reset = 1'b0;
        repeat (4) cyc();
        chk("rst_rel_early", 0, rise_a, 0);
        cyc();
        chk("rst_rel_rise", 0, rise_a, 4'b1111);
        repeat (5) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
